// File: rtl/cpa_19_pipe.sv
// cpa_19_pipe: two-stage pipelined carry-propagate adder that resolves a
// carry/save vector pair from a CSA compressor into a binary sum.
// Stage 1 adds the low SPLIT bits. Stage 2 adds the high segment together
// with the low-segment carry.
// Uses valid/ready handshaking on both sides.
// Optional feature: define CPA_OVF_STICKY_EN to build the sticky overflow flag.
module cpa_19_pipe #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned SPLIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  input  logic             clr_ovf,
  output logic             ovf_sticky
);

  localparam int unsigned HW = WIDTH - SPLIT;

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [SPLIT:0]   r_lo;
  logic [HW-1:0]    r_c_hi;
  logic [HW-1:0]    r_s_hi;
  logic [SPLIT-1:0] r_lo2;
  logic [HW:0]      r_hi;

  logic             w_adv1;
  logic             w_adv2;
  logic [SPLIT:0]   w_lo;
  logic [HW:0]      w_hi;

  // A stage advances when it is empty or when its downstream slot frees up.
  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  assign w_lo = {1'b0, C[SPLIT-1:0]} + {1'b0, S[SPLIT-1:0]};
  assign w_hi = {1'b0, r_c_hi} + {1'b0, r_s_hi} + {{HW{1'b0}}, r_lo[SPLIT]};

  // Stage 1: low-segment add, pass the high segments through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_lo       <= '0;
      r_c_hi     <= '0;
      r_s_hi     <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_lo   <= w_lo;
        r_c_hi <= C[WIDTH-1:SPLIT];
        r_s_hi <= S[WIDTH-1:SPLIT];
      end
    end
  end

  // Stage 2: high-segment add including the carry out of the low segment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_lo2      <= '0;
      r_hi       <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_lo2 <= r_lo[SPLIT-1:0];
        r_hi  <= w_hi;
      end
    end
  end

  // Stale stage-2 contents are masked so only valid results are visible.
  assign out_valid = r_s2_valid;
  assign busy      = r_s1_valid | r_s2_valid;
  assign sum       = r_s2_valid ? {r_hi[HW-1:0], r_lo2} : '0;
  assign cout      = r_s2_valid & r_hi[HW];

`ifdef CPA_OVF_STICKY_EN
  logic r_ovf;

  // Sticky overflow: a carry-out on an output transfer sets it.
  // If set and clear happen in the same cycle, the set takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (out_valid && out_ready && cout) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf;
`else
  logic w_unused_clr_ovf;
  assign w_unused_clr_ovf = clr_ovf;
  assign ovf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_cpa_19_pipe.sv
// Directed self-checking bench for cpa_19_pipe (WIDTH=19, SPLIT=10).
module tb_cpa_19_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] C;
  logic [18:0] S;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] sum;
  logic        cout;
  logic        busy;
  logic        clr_ovf;
  logic        ovf_sticky;

  int total = 0;
  int bad   = 0;

  cpa_19_pipe #(.WIDTH(19), .SPLIT(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .C(C), .S(S), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .clr_ovf(clr_ovf),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  // advance one clock, then settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; C = '0; S = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if ({sum, cout, ovf_sticky} !== 21'h0) begin bad++; $display("FAIL rst_data got sum=%h cout=%b ovf=%b exp=0", sum, cout, ovf_sticky); end
    rst = 1'b0;
    step();
    total++; if ({out_valid, busy, in_ready} !== 3'b001) begin bad++; $display("FAIL post_rst_flags got=%b exp=001", {out_valid, busy, in_ready}); end
  endtask

  task automatic test_carry_split();
    C = 19'h003FF; S = 19'h00001; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if ({out_valid, busy} !== 2'b01) begin bad++; $display("FAIL split_lat1 got ov/busy=%b exp=01", {out_valid, busy}); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL split_valid got=%b exp=1", out_valid); end
    total++; if ({cout, sum} !== {1'b0, 19'h00400}) begin bad++; $display("FAIL split_sum got=%b_%h exp=0_00400", cout, sum); end
    step();
    total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL split_drain got=%b exp=00", {out_valid, busy}); end
  endtask

  task automatic test_overflow();
    C = 19'h7FFFF; S = 19'h00001; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++; if ({out_valid, cout, sum} !== {1'b1, 1'b1, 19'h00000}) begin bad++; $display("FAIL ovf_sum got v=%b c=%b s=%h exp v=1 c=1 s=00000", out_valid, cout, sum); end
    step();
`ifdef CPA_OVF_STICKY_EN
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_sticky); end
`else
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL ovf_disabled got=%b exp=0", ovf_sticky); end
`endif
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [18:0] a   [3] = '{19'd1, 19'd3, 19'd5};
    logic [18:0] b   [3] = '{19'd2, 19'd4, 19'd6};
    logic [18:0] exp [3] = '{19'd3, 19'd7, 19'd11};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin in_valid = 1'b1; C = a[i]; S = b[i]; end
      else in_valid = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
      step();
      if (i >= 1 && i <= 3) begin
        total++; if ({out_valid, sum} !== {1'b1, exp[i-1]}) begin bad++; $display("FAIL b2b_sum cyc=%0d got v=%b s=%0d exp v=1 s=%0d", i, out_valid, sum, exp[i-1]); end
      end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [18:0] a   [4] = '{19'd10, 19'd20, 19'd30, 19'd40};
    logic [18:0] b   [4] = '{19'd1,  19'd2,  19'd3,  19'd4};
    logic [18:0] exp [4] = '{19'd11, 19'd22, 19'd33, 19'd44};
    int idx = 0;
    int oidx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin C = a[idx]; S = b[idx]; end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low cyc=%0d got=%b exp=0", cyc, in_ready); end
        total++; if ({out_valid, sum} !== {1'b1, 19'd11}) begin bad++; $display("FAIL bp_hold cyc=%0d got v=%b s=%0d exp v=1 s=11", cyc, out_valid, sum); end
      end
      if (cyc == 5) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (oidx >= 4 || sum !== exp[oidx]) begin bad++; $display("FAIL bp_order idx=%0d got=%0d", oidx, sum); end
        oidx++;
      end
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    total++; if (idx != 4 || oidx != 4) begin bad++; $display("FAIL bp_count got in=%0d out=%0d exp 4/4", idx, oidx); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0; in_valid = 1'b1; C = 19'h00100; S = 19'h00200;
    step();
    C = 19'h00300;
    step();
    in_valid = 1'b0;
    total++; if ({out_valid, busy, in_ready} !== 3'b110) begin bad++; $display("FAIL mid_full got=%b exp=110", {out_valid, busy, in_ready}); end
    #2 rst = 1'b1;
    #1;
    total++; if ({out_valid, busy, cout, sum} !== 22'h0) begin bad++; $display("FAIL mid_async got v=%b b=%b c=%b s=%h exp 0", out_valid, busy, cout, sum); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if ({out_valid, busy, in_ready} !== 3'b001) begin bad++; $display("FAIL mid_post got=%b exp=001", {out_valid, busy, in_ready}); end
    C = 19'h12345; S = 19'h01111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_lat1 got=%b exp=0", out_valid); end
    step();
    total++; if ({out_valid, cout, sum} !== {1'b1, 1'b0, 19'h13456}) begin bad++; $display("FAIL mid_first got v=%b c=%b s=%h exp v=1 c=0 s=13456", out_valid, cout, sum); end
  endtask

  initial begin
    test_reset();
    test_carry_split();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/cpa_19_pipe.md
CPA_19_PIPE -- requirements
Module: cpa_19_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 19, operand/sum width in bits.
REQ-002 SHALL have parameter SPLIT, default 10, width of the low segment; legal range 1..WIDTH-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  C/S operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 SHALL have port C  input  WIDTH  carry vector from the 6:2 CSA compressor, already left-shifted.
REQ-008 SHALL have port S  input  WIDTH  save vector from the 6:2 CSA compressor.
REQ-009 SHALL have port out_valid  output  1  resolved sum present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the sum.
REQ-011 SHALL have port sum  output  WIDTH  (C+S) mod 2^WIDTH.
REQ-012 SHALL have port cout  output  1  bit WIDTH of C+S.
REQ-013 SHALL have port busy  output  1  OR of all stage-valid flags.
REQ-014 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-015 SHALL have port ovf_sticky  output  1  sticky overflow flag (see Configuration).

Function
REQ-016 SHALL transfer input only when in_valid && in_ready, and output only when out_valid && out_ready.
REQ-017 Stage 1 SHALL register lo = C[SPLIT-1:0]+S[SPLIT-1:0] (SPLIT+1 bits) plus unmodified C/S high segments, and set s1_valid.
REQ-018 Stage 2 SHALL register hi = C_hi+S_hi+lo[SPLIT] and drive sum = {hi[WIDTH-SPLIT-1:0], lo[SPLIT-1:0]}, cout = hi[WIDTH-SPLIT].
REQ-019 Latency SHALL be exactly 2 cycles from input transfer to out_valid with out_ready held high.
REQ-020 Throughput SHALL be one pair per cycle while out_ready is high.
REQ-021 s2 SHALL advance when !s2_valid || out_ready; s1 SHALL advance when !s1_valid || s2 advances; in_ready SHALL equal the s1 advance condition (combinational from out_ready permitted).
REQ-022 While out_valid && !out_ready, sum, cout and out_valid SHALL hold stable; no pair SHALL be dropped or duplicated.
REQ-023 With both stages full and out_ready low, in_ready SHALL be 0; in the cycle out_ready rises, in_ready SHALL be 1 and both stages SHALL shift simultaneously.
REQ-024 Stage valid flags SHALL clear when a stage drains without a new entry.
REQ-025 Data registers SHALL load only on advance; contents of invalid stages are don't-care but SHALL not reach sum/cout while out_valid is 0.

Reset
REQ-026 rst SHALL asynchronously clear s1_valid, s2_valid, all data registers, sum, cout and ovf_sticky to 0.
REQ-027 During and in the first cycle after rst deassertion, out_valid=0, busy=0, in_ready=1.
REQ-028 rst mid-operation SHALL discard all in-flight pairs; no partial output SHALL appear.

Configuration
REQ-029 With macro CPA_OVF_STICKY_EN defined, ovf_sticky SHALL set on any output transfer with cout=1 and clear on clr_ovf; when both occur in the same cycle, set SHALL win.
REQ-030 Without CPA_OVF_STICKY_EN, ovf_sticky SHALL be constant 0, clr_ovf SHALL be ignored, and no sticky register SHALL be synthesized.

Verification
REQ-031 C=0x003FF, S=0x00001, out_ready=1 -> out_valid 2 cycles later, sum=0x00400, cout=0 (carry across split).
REQ-032 C=0x7FFFF, S=0x00001 -> sum=0x00000, cout=1; with CPA_OVF_STICKY_EN, ovf_sticky=1 next cycle, cleared by clr_ovf pulse.
REQ-033 Back-to-back pairs (1,2),(3,4),(5,6) every cycle, out_ready=1 -> sums 3,7,11 on 3 consecutive cycles, in_ready never low.
REQ-034 out_ready=0 for 5 cycles while streaming 4 pairs -> in_ready drops after 2 accepted, sum held stable; on release all 4 sums emerge in order with none lost.
REQ-035 rst asserted with both stages valid -> out_valid, busy, sum, cout =0 immediately (asynchronously); first post-reset pair C=0x12345,S=0x01111 -> sum=0x13456 after 2 cycles.
